// File: rtl/bcd_serial_subtractor_if.sv
// Start/done handshake bundle for the digit-serial BCD subtractor.
// The controller drives operands and start; the subtractor returns the sign-magnitude result.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   z;
    logic                  neg;
    logic                  err;

    modport master (
        output start, a, b,
        input  busy, done, z, neg, err
    );

    modport slave (
        input  start, a, b,
        output busy, done, z, neg, err
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: a - b, one digit per clock, LSD first, sign-magnitude result.
// A negative SUB pass leaves the ten's complement, which a second serial pass recomplements.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bcd_serial_subtractor_if.slave    bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SUB,
        FIX
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          br;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  r_sh;
    logic [4:0]    step;
    logic [W-1:0]  r_next;

    // Returns {borrow_out, digit}; the signed intermediate spans -10..9.
    function automatic logic [4:0] sub_digit(input logic [3:0] x, input logic [3:0] y,
                                             input logic bin);
        logic signed [5:0] d;
        d = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({5'b00000, bin});
        if (d < 0)
            return {1'b1, 4'(d + 6'sd10)};
        else
            return {1'b0, 4'(d)};
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9)
                bad = 1'b1;
        return bad;
    endfunction

    always_comb begin
        step = 5'd0;
        if (state == FIX)
            step = sub_digit(4'h0, r_sh[3:0], br);
        else
            step = sub_digit(a_sh[3:0], b_sh[3:0], br);
        r_next = (r_sh >> 4) | (W'(step[3:0]) << (W - 4));
    end

    // Operand and result shift registers carry no reset; control qualifies them.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_sh <= bus.a;
                    b_sh <= bus.b;
                end
            end
            SUB: begin
                a_sh <= a_sh >> 4;
                b_sh <= b_sh >> 4;
                r_sh <= r_next;
            end
            FIX: begin
                r_sh <= r_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            br       <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.z    <= '0;
            bus.neg  <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx      <= '0;
                        br       <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (has_bad(a_sh) || has_bad(b_sh)) begin
                        bus.err  <= 1'b1;
                        bus.z    <= '0;
                        bus.neg  <= 1'b0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    br  <= step[4];
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx <= '0;
                        if (step[4]) begin
                            br    <= 1'b0;
                            state <= FIX;
                        end else begin
                            bus.z    <= r_next;
                            bus.neg  <= 1'b0;
                            bus.err  <= 1'b0;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                FIX: begin
                    br  <= step[4];
                    idx <= idx + 1'b1;
                    // The final recomplement borrow is dropped; the sign lives in neg.
                    if (idx == LAST) begin
                        idx      <= '0;
                        br       <= 1'b0;
                        bus.z    <= r_next;
                        bus.neg  <= 1'b1;
                        bus.err  <= 1'b0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: directed cases plus random operands against an integer model.
module tb_bcd_serial_subtractor;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bcd_serial_subtractor_if #(.DIGITS(D)) bus ();

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer-level reference: decode both operands, subtract, re-encode the magnitude.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] z, output logic n,
                                  output logic e, output int lat);
        int av, bv, df, p;
        e = 1'b0; av = 0; bv = 0; p = 1; z = '0; n = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e = 1'b1;
            av += int'(a[4*i +: 4]) * p;
            bv += int'(b[4*i +: 4]) * p;
            p  *= 10;
        end
        if (e) begin
            lat = 1;
        end else begin
            df = av - bv;
            n  = (df < 0);
            if (n) df = -df;
            for (int i = 0; i < D; i++) begin
                z[4*i +: 4] = 4'(df % 10);
                df = df / 10;
            end
            lat = n ? 2*D + 1 : D + 1;
        end
    endfunction

    // Drives one operation and reports what was observed; lat=0 means done never came.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] z, output logic n,
                         output logic e, output logic busy_ok, output logic pulse_ok);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        busy_ok = (bus.busy === 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; z = 'x; n = 1'bx; e = 1'bx; pulse_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = k; z = bus.z; n = bus.neg; e = bus.err;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
            pulse_ok = (bus.done === 1'b0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.z, bus.neg, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b z=%h neg=%b err=%b, required all zero",
                     bus.busy, bus.done, bus.z, bus.neg, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta[8], tb[8], ez[8];
        logic         en[8], ee[8];
        int           el[8];
        int lat; logic [W-1:0] z; logic n, e, bok, pok;
        ta = '{16'h4321, 16'h0100, 16'h1000, 16'h1234, 16'h0000, 16'h12A4, 16'h0000, 16'h9999};
        tb = '{16'h1234, 16'h0001, 16'h0001, 16'h4321, 16'h0001, 16'h0000, 16'hF000, 16'h9999};
        ez = '{16'h3087, 16'h0099, 16'h0999, 16'h3087, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        el = '{5, 5, 5, 9, 9, 1, 1, 5};
        for (int i = 0; i < 8; i++) begin
            do_op(ta[i], tb[i], lat, z, n, e, bok, pok);
            checks++;
            if (lat != el[i] || z !== ez[i] || n !== en[i] || e !== ee[i]) begin
                errors++;
                $display("FAIL directed_%0d %h-%h: lat=%0d z=%h neg=%b err=%b, required lat=%0d z=%h neg=%b err=%b",
                         i, ta[i], tb[i], lat, z, n, e, el[i], ez[i], en[i], ee[i]);
            end
            checks++;
            if (!bok || !pok) begin
                errors++;
                $display("FAIL directed_hs_%0d: busy_ok=%b pulse_ok=%b, required 1 1", i, bok, pok);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, ez, z;
        logic en, ee, n, e, bok, pok;
        int el, lat;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < D; i++) begin
                a[4*i +: 4] = 4'($urandom_range(0, 9));
                b[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    a[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
                else
                    b[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            end
            if ($urandom_range(0, 9) == 0) b = a;
            model(a, b, ez, en, ee, el);
            do_op(a, b, lat, z, n, e, bok, pok);
            checks++;
            if (lat != el || z !== ez || n !== en || e !== ee || !bok || !pok) begin
                errors++;
                $display("FAIL random_%0d %h-%h: lat=%0d z=%h neg=%b err=%b hs=%b%b, required lat=%0d z=%h neg=%b err=%b hs=11",
                         t, a, b, lat, z, n, e, bok, pok, el, ez, en, ee);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b, ez, z;
        logic en, ee, n, e, bok, pok;
        int el, lat;
        // do_op starts on the negedge right after the done cycle, i.e. the cycle after done.
        a = 16'h0500; b = 16'h0123;
        for (int t = 0; t < 3; t++) begin
            model(a, b, ez, en, ee, el);
            do_op(a, b, lat, z, n, e, bok, pok);
            checks++;
            if (lat != el || z !== ez || n !== en || e !== ee) begin
                errors++;
                $display("FAIL back_to_back_%0d: lat=%0d z=%h neg=%b err=%b, required lat=%0d z=%h neg=%b err=%b",
                         t, lat, z, n, e, el, ez, en, ee);
            end
            a = b; b = 16'h0987;
        end
    endtask

    task automatic test_busy_ignore;
        int dones, lat;
        dones = 0; lat = 0;
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h4321; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'h9999; bus.b = 16'h0000; bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (lat == 0) lat = k;
            end
            @(negedge clk);
            bus.start = (k == 2 || k == 5 || k == 7);
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1 || lat != 9) begin
            errors++;
            $display("FAIL busy_ignore_pulses: dones=%0d first_at=%0d, required 1 at 9", dones, lat);
        end
        checks++;
        if (bus.z !== 16'h3087 || bus.neg !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_result: z=%h neg=%b err=%b, required 3087 1 0",
                     bus.z, bus.neg, bus.err);
        end
    endtask

    task automatic test_reset_mid;
        int dones, lat;
        logic [W-1:0] z; logic n, e, bok, pok;
        dones = 0;
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h4321; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.z !== '0 || bus.done !== 1'b0 || bus.neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b z=%h done=%b neg=%b, required 0 0000 0 0",
                     bus.busy, bus.z, bus.done, bus.neg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_no_done: dones=%0d, required 0", dones);
        end
        do_op(16'h0042, 16'h0017, lat, z, n, e, bok, pok);
        checks++;
        if (lat != 5 || z !== 16'h0025 || n !== 1'b0 || e !== 1'b0 || !bok || !pok) begin
            errors++;
            $display("FAIL reset_recover: lat=%0d z=%h neg=%b err=%b, required 5 0025 0 0", lat, z, n, e);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
